ex_operand_stage: RTL
=====================

# ex_operand_stage

Decode-to-execute pipeline stage that sits directly upstream of the ALU. Each cycle it takes one decoded RV32I instruction, maps opcode/funct3/funct7[5] to the 4-bit ALU operation code, and selects the A/B operands (register, PC, immediate or constant 4), with optional forwarding from EX/MEM and MEM/WB. The result is captured in a stall/flush-capable pipeline register whose outputs drive the ALU's `alu_op`, `A` and `B` inputs directly.

## Interface
- `XLEN`, 32, datapath width; must match the ALU (32).
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  decoded instruction present.
- `in_pc`  in  XLEN  instruction PC.
- `in_opcode`  in  7  instruction bits [6:0].
- `in_funct3`  in  3  instruction bits [14:12].
- `in_funct7_5`  in  1  instruction bit 30.
- `in_rs1_addr`, `in_rs2_addr`, `in_rd_addr`  in  5 each  register indices.
- `in_rs1_data`, `in_rs2_data`  in  XLEN  register-file read data.
- `in_imm`  in  XLEN  sign-extended immediate from the decoder.
- `stall`  in  1  hold the pipeline register.
- `flush`  in  1  squash the instruction being captured.
- `exmem_wr_en`, `memwb_wr_en`  in  1  forwarding source valid.
- `exmem_rd`, `memwb_rd`  in  5  forwarding destination index.
- `exmem_data`, `memwb_data`  in  XLEN  forwarding value.
- `out_valid`  out  1  registered instruction valid.
- `alu_op`  out  4  ALU op code.
- `alu_a`, `alu_b`  out  XLEN  ALU operands.
- `out_store_data`  out  XLEN  resolved rs2 value for stores.
- `out_rd_addr`  out  5  destination index.
- `out_reg_wr`  out  1  instruction writes rd.
- `out_illegal`  out  1  unrecognised opcode.

## Operation
- ALU codes: ADD 0, SUB 1, SLL 2, SRL 3, SRA 4, SLT 5, SLTU 6, XOR 7, OR 8, AND 9, PASS_B 10.
- OP (0110011) / OP-IMM (0010011), by funct3: 000 ADD (SUB only for OP with funct7_5=1); 001 SLL; 010 SLT; 011 SLTU; 100 XOR; 101 SRL, or SRA if funct7_5=1 (both opcodes); 110 OR; 111 AND.
- Operands: OP gives A=rs1, B=rs2. OP-IMM gives A=rs1, B=imm.
- LUI (0110111): PASS_B, B=imm, A=0.
- AUIPC (0010111): ADD, A=pc, B=imm.
- LOAD (0000011) and STORE (0100011): ADD, A=rs1, B=imm.
- JAL (1101111) and JALR (1100111): ADD, A=pc, B=4 (link value).
- BRANCH (1100011): SUB, A=rs1, B=rs2.
- Any other opcode: `out_illegal`=1, ADD with A=B=0, `out_reg_wr`=0.
- `out_reg_wr`=1 for OP, OP-IMM, LUI, AUIPC, LOAD, JAL, JALR, and only when rd≠0; 0 for all other opcodes.
- Forwarding is applied per source before capture. Priority: EX/MEM match (wr_en and rd==rs≠0), then MEM/WB match, then register-file data. Index x0 is never forwarded.
- `out_store_data` is always the resolved rs2 value.

## Timing
- Latency is 1 cycle: inputs sampled in cycle N appear on the outputs in cycle N+1.
- Reset, asynchronous, any time: all outputs 0, i.e. `alu_op`=ADD, operands 0, `out_valid`=0. Any in-flight instruction is discarded.
- Per edge:
  - `flush`=1: `out_valid`, `out_reg_wr` and `out_illegal` go to 0, `alu_op` to ADD, operands to 0. Flush wins over stall.
  - `stall`=1 with `flush`=0: all outputs hold. Upstream re-presents the same instruction; forwarding is re-evaluated on release.
  - Otherwise: capture. If `in_valid`=0, outputs load the flush values.
- When `out_valid`=0, `out_reg_wr` and `out_illegal` are guaranteed 0.
- The output path is purely registered: no combinational path from inputs to outputs.

## Configuration
- `EX_FORWARD_EN` defined: the forwarding muxes are compiled in as described above.
- Not defined: the forwarding ports remain but are ignored. Operands come from `in_rs1_data`/`in_rs2_data` only, and the hazard unit stalls instead.

## Test plan
- OP SUB: funct7_5=1, rs1=5, rs2=3. Next cycle: `alu_op`=1, A=5, B=3, `out_reg_wr`=1.
- OP-IMM SRAI: funct3=101, funct7_5=1, rs1=0x80000000, imm=4. Result: `alu_op`=4, B=4. The same with funct7_5=0 gives `alu_op`=3.
- Forwarding:
  - With `EX_FORWARD_EN` and both sources matching rs1=x7 (exmem_data=0xAA, memwb_data=0xBB): A=0xAA.
  - With only MEM/WB matching: A=0xBB.
  - With rs1=x0: A=0 from `in_rs1_data` regardless of forwarding.
- LUI imm=0x12345000: `alu_op`=10, B=0x12345000. JAL at pc=0x100: `alu_op`=0, A=0x100, B=4.
- Stall and flush: capture ADD, then assert stall for 2 cycles while inputs change, and outputs hold. Assert stall and flush together: `out_valid`=0, `alu_op`=0.
- Reset and illegal opcode:
  - Drop rst_n mid-stream: outputs 0 immediately, without waiting for a clock edge.
  - Opcode 0x7F: `out_illegal`=1, `out_reg_wr`=0, `alu_op`=0.

Source files
------------

// File: rtl/ex_operand_stage.sv
// ex_operand_stage: RV32I decode-to-execute register feeding the ALU.
// Maps opcode/funct3/funct7[5] to alu_op and selects the A/B operands.
// Operands come from a register, the PC, the immediate or the constant 4.
// Outputs are purely registered (1-cycle latency); flush wins over stall.
// EX_FORWARD_EN: when defined, rs1/rs2 forward from EX/MEM, then MEM/WB.
// Ports: clk, rst_n (async, active low); in_* decoded instruction;
//        stall/flush pipeline control; exmem_*/memwb_* forwarding sources;
//        out_valid, alu_op, alu_a, alu_b, out_store_data, out_rd_addr,
//        out_reg_wr, out_illegal.
module ex_operand_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    input  logic [XLEN-1:0] in_pc,
    input  logic [6:0]      in_opcode,
    input  logic [2:0]      in_funct3,
    input  logic            in_funct7_5,
    input  logic [4:0]      in_rs1_addr,
    input  logic [4:0]      in_rs2_addr,
    input  logic [4:0]      in_rd_addr,
    input  logic [XLEN-1:0] in_rs1_data,
    input  logic [XLEN-1:0] in_rs2_data,
    input  logic [XLEN-1:0] in_imm,
    input  logic            stall,
    input  logic            flush,
    input  logic            exmem_wr_en,
    input  logic            memwb_wr_en,
    input  logic [4:0]      exmem_rd,
    input  logic [4:0]      memwb_rd,
    input  logic [XLEN-1:0] exmem_data,
    input  logic [XLEN-1:0] memwb_data,
    output logic            out_valid,
    output logic [3:0]      alu_op,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [XLEN-1:0] out_store_data,
    output logic [4:0]      out_rd_addr,
    output logic            out_reg_wr,
    output logic            out_illegal
);

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SRL  = 4'd3;
    localparam logic [3:0] ALU_SRA  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_XOR  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;
    localparam logic [3:0] ALU_PASS = 4'd10;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;

`ifdef EX_FORWARD_EN
    // EX/MEM is younger than MEM/WB, so it overrides; x0 never forwards.
    always_comb begin
        rs1_val = in_rs1_data;
        if (memwb_wr_en && in_rs1_addr != 5'd0 && memwb_rd == in_rs1_addr)
            rs1_val = memwb_data;
        if (exmem_wr_en && in_rs1_addr != 5'd0 && exmem_rd == in_rs1_addr)
            rs1_val = exmem_data;
    end

    always_comb begin
        rs2_val = in_rs2_data;
        if (memwb_wr_en && in_rs2_addr != 5'd0 && memwb_rd == in_rs2_addr)
            rs2_val = memwb_data;
        if (exmem_wr_en && in_rs2_addr != 5'd0 && exmem_rd == in_rs2_addr)
            rs2_val = exmem_data;
    end
`else
    // Forwarding ports stay on the boundary; the hazard unit stalls instead.
    logic fwd_unused;
    assign fwd_unused = ^{exmem_wr_en, memwb_wr_en, exmem_rd, memwb_rd,
                          exmem_data, memwb_data, in_rs1_addr, in_rs2_addr};
    assign rs1_val = in_rs1_data;
    assign rs2_val = in_rs2_data;
`endif

    logic is_op, is_opimm, is_lui, is_auipc, is_ldst, is_jmp, is_br;

    assign is_op    = (in_opcode == OPC_OP);
    assign is_opimm = (in_opcode == OPC_OPIMM);
    assign is_lui   = (in_opcode == OPC_LUI);
    assign is_auipc = (in_opcode == OPC_AUIPC);
    assign is_ldst  = (in_opcode == OPC_LOAD) || (in_opcode == OPC_STORE);
    assign is_jmp   = (in_opcode == OPC_JAL) || (in_opcode == OPC_JALR);
    assign is_br    = (in_opcode == OPC_BRANCH);

    // funct7_5 selects SUB only for register-register OP; SRA for both.
    function automatic logic [3:0] arith_op(
        input logic [2:0] f3,
        input logic       f7_5,
        input logic       reg_reg
    );
        logic [3:0] op;
        unique case (f3)
            3'b000:  op = (reg_reg && f7_5) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = f7_5 ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    logic [3:0]      op_d;
    logic [XLEN-1:0] a_d;
    logic [XLEN-1:0] b_d;
    logic            wr_d;
    logic            ill_d;

    always_comb begin
        op_d  = ALU_ADD;
        a_d   = '0;
        b_d   = '0;
        wr_d  = 1'b0;
        ill_d = 1'b0;
        unique case (1'b1)
            is_op: begin
                op_d = arith_op(in_funct3, in_funct7_5, 1'b1);
                a_d  = rs1_val;
                b_d  = rs2_val;
                wr_d = 1'b1;
            end
            is_opimm: begin
                op_d = arith_op(in_funct3, in_funct7_5, 1'b0);
                a_d  = rs1_val;
                b_d  = in_imm;
                wr_d = 1'b1;
            end
            is_lui: begin
                op_d = ALU_PASS;
                b_d  = in_imm;
                wr_d = 1'b1;
            end
            is_auipc: begin
                a_d  = in_pc;
                b_d  = in_imm;
                wr_d = 1'b1;
            end
            is_ldst: begin
                a_d  = rs1_val;
                b_d  = in_imm;
                wr_d = (in_opcode == OPC_LOAD);
            end
            is_jmp: begin
                a_d  = in_pc;
                b_d  = XLEN'(4);
                wr_d = 1'b1;
            end
            is_br: begin
                op_d = ALU_SUB;
                a_d  = rs1_val;
                b_d  = rs2_val;
            end
            default: ill_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid      <= 1'b0;
            alu_op         <= ALU_ADD;
            alu_a          <= '0;
            alu_b          <= '0;
            out_store_data <= '0;
            out_rd_addr    <= '0;
            out_reg_wr     <= 1'b0;
            out_illegal    <= 1'b0;
        end else if (flush || (!stall && !in_valid)) begin
            out_valid      <= 1'b0;
            alu_op         <= ALU_ADD;
            alu_a          <= '0;
            alu_b          <= '0;
            out_store_data <= '0;
            out_rd_addr    <= '0;
            out_reg_wr     <= 1'b0;
            out_illegal    <= 1'b0;
        end else if (!stall) begin
            out_valid      <= 1'b1;
            alu_op         <= op_d;
            alu_a          <= a_d;
            alu_b          <= b_d;
            out_store_data <= rs2_val;
            out_rd_addr    <= in_rd_addr;
            out_reg_wr     <= wr_d && (in_rd_addr != 5'd0);
            out_illegal    <= ill_d;
        end
    end

endmodule
